// File: rtl/wb_port_arb_pkg.sv
// Shared definitions for the writeback port arbiter and its result buffer.
package wb_port_arb_pkg;

    localparam int DEF_FIFO_DEPTH = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Which producer owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        PIPE   = 2'd1,
        BUF    = 2'd2,
        DIRECT = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_res_fifo.sv
// Small FIFO holding multi-cycle results that lost arbitration for the
// register-file write port. Also exposes a per-entry destination match for
// two query registers so decode can see pending writes.
module wb_res_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [4:0]               push_rd,
    input  logic [31:0]              push_val,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [4:0]               head_rd,
    output logic [31:0]              head_val,
    input  logic [4:0]               query_a,
    input  logic [4:0]               query_b,
    output logic [DEPTH-1:0]         match_a,
    output logic [DEPTH-1:0]         match_b
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]    rd_mem  [DEPTH];
    logic [31:0]   val_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head_rd  = rd_mem[rd_ptr];
    assign head_val = val_mem[rd_ptr];

    // Entry storage; contents are only meaningful while covered by count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]  <= push_rd;
            val_mem[wr_ptr] <= push_val;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            logic          live;
            offset = PW'(i) - rd_ptr;
            live   = {1'b0, offset} < count;
            match_a[i] = live && (rd_mem[i] == query_a);
            match_b[i] = live && (rd_mem[i] == query_b);
        end
    end

endmodule

// File: rtl/wb_port_arb.sv
// Writeback port arbiter: merges the pipeline WB stage and a multi-cycle
// unit onto one register-file write port, buffering mc results that lose and
// forcing a pipeline stall when a buffered result has waited too long.
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_val,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_val,
    input  logic [4:0]  rs1_q,
    input  logic [4:0]  rs2_q,
    output logic        pend_rs1,
    output logic        pend_rs2,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]         count;
    logic [4:0]            head_rd;
    logic [31:0]           head_val;
    logic [FIFO_DEPTH-1:0] hit1;
    logic [FIFO_DEPTH-1:0] hit2;
    logic [SW-1:0]         starve_cnt;
    logic                  stall_q;
    logic                  empty;
    logic                  pipe_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;
    wb_src_e               src;

    assign empty    = (count == '0);
    assign mc_ready = (count < CW'(FIFO_DEPTH));
    assign pipe_ok  = pipe_we && (pipe_rd != 5'd0);
    assign accept   = mc_valid && mc_ready && (mc_rd != 5'd0);

    // The counter stays saturated during the stall cycle, so the second
    // cycle at STARVE_MAX (the forced pop) is masked to keep a single pulse.
    assign stall_req = (starve_cnt == SW'(STARVE_MAX)) && !stall_q;

    // Pick the write-port owner for this cycle in fixed priority order.
    always_comb begin
        src = NONE;
        if (stall_q && !empty)
            src = BUF;
        else if (pipe_ok)
            src = PIPE;
        else if (!empty)
            src = BUF;
        else if (accept)
            src = DIRECT;
    end

    assign pop  = (src == BUF);
    assign push = accept && (src != DIRECT);

    wb_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_rd  (mc_rd),
        .push_val (mc_val),
        .pop      (pop),
        .count    (count),
        .head_rd  (head_rd),
        .head_val (head_val),
        .query_a  (rs1_q),
        .query_b  (rs2_q),
        .match_a  (hit1),
        .match_b  (hit2)
    );

    assign pend_rs1 = (rs1_q != 5'd0) && ((|hit1) || (rf_we && (rf_waddr == rs1_q)));
    assign pend_rs2 = (rs2_q != 5'd0) && ((|hit2) || (rf_we && (rf_waddr == rs2_q)));

    // Register the selected write and track how long the buffer head has waited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= stall_req;
            case (src)
                PIPE: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= pipe_rd;
                    rf_wdata <= pipe_val;
                end
                BUF: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= head_rd;
                    rf_wdata <= head_val;
                end
                DIRECT: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= mc_rd;
                    rf_wdata <= mc_val;
                end
                default: rf_we <= 1'b0;
            endcase
            if (pop || empty)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: doc/wb_port_arb.md
WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 2: entries in the multi-cycle result buffer (power of two, 2..8).
REQ-002 SHALL provide parameter STARVE_MAX, default 4: consecutive lost cycles before a buffered result forces a pipeline stall.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pipe_we  in  1  pipeline WB stage requests a register write.
- pipe_rd  in  5  pipeline destination register.
- pipe_val  in  32  pipeline writeback value (load / PC+4 / ALU select result).
- mc_valid  in  1  multi-cycle unit result valid.
- mc_ready  out  1  arbiter accepts mc result this cycle.
- mc_rd  in  5  multi-cycle destination register.
- mc_val  in  32  multi-cycle result value.
- rs1_q, rs2_q  in  5 each  decode-stage source registers for the pending check.
- pend_rs1, pend_rs2  out  1 each  queried register has a buffered, unwritten result.
- stall_req  out  1  pipeline must present an idle WB slot next cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

Function
REQ-004 SHALL treat pipe_we=1 with pipe_rd=0 as an idle slot; no write to x0 is ever issued.
REQ-005 SHALL drive mc_ready = (buffer count < FIFO_DEPTH); handshake completes when mc_valid and mc_ready are both high.
REQ-006 SHALL discard accepted mc results with mc_rd=0 (handshake completes, nothing buffered).
REQ-007 Per cycle, SHALL select the rf write source, highest priority first: (a) buffer head when stall_req was high the previous cycle; (b) pipeline when pipe_we=1 and pipe_rd!=0; (c) buffer head when non-empty; (d) accepted mc result direct, when buffer empty; (e) none.
REQ-008 Selected write SHALL appear on rf_we/rf_waddr/rf_wdata at the next rising edge (1-cycle latency); rf_we=0 when nothing is selected.
REQ-009 An accepted mc result not written directly SHALL be pushed at the buffer tail; push and pop in the same cycle are allowed at any count except push when full (blocked by mc_ready).
REQ-010 Buffer SHALL be FIFO-ordered with read/write pointers wrapping modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
REQ-011 Starvation counter SHALL increment each cycle the buffer is non-empty and its head is not popped, clear on any pop or when empty, and saturate at STARVE_MAX.
REQ-012 stall_req SHALL be high for one cycle when the counter equals STARVE_MAX; the following cycle pops the head per REQ-007(a) even if pipe_we=1 (pipeline write beyond a protocol violation is dropped and counted by assertion only).
REQ-013 pend_rs1/pend_rs2 SHALL be combinational: high if any valid buffer entry or an in-flight direct write (rf_we=1) matches the query and the query is non-zero.
REQ-014 If pipe_rd matches a buffered entry, both writes SHALL still be issued in REQ-007 order; WAW prevention is the decode stage's job via pend_rs*.

Reset
REQ-015 On rst_n low, asynchronously: count, pointers, starvation counter = 0; rf_we=0, rf_waddr=0, rf_wdata=0; stall_req=0; mc_ready=1 after reset.
REQ-016 Reset mid-operation SHALL discard all buffered results without issuing writes; buffer data RAM need not be cleared.

Structure
REQ-017 Shared package SHALL hold the write-source select enum (NONE, PIPE, BUF, DIRECT) and the default FIFO_DEPTH/STARVE_MAX constants.
REQ-018 Buffer SHALL be one sub-module, wb_res_fifo (push/pop/count/head, parallel entry-address match outputs); arbitration and starvation logic stay in wb_port_arb.

Verification
REQ-019 Idle pipe, empty buffer, mc_valid rd=5 val=0xDEAD_BEEF -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; count stays 0.
REQ-020 pipe_we=1 rd=3 val=0x11 with mc_valid rd=7 val=0x22 -> cycle+1 writes x3=0x11, then idle slot writes x7=0x22; pend_rs1 (rs1_q=7) high until x7 written.
REQ-021 pipe_we held high, two mc results pushed (FIFO_DEPTH=2) -> mc_ready low when full; after 4 lost cycles stall_req pulses once; next cycle writes oldest entry.
REQ-022 mc_valid with mc_rd=0, and pipe_we=1 with pipe_rd=0 -> rf_we stays 0, count stays 0.
REQ-023 rst_n asserted with 2 buffered entries -> outputs zero immediately, no writes after release, mc_ready=1.
